display_scan_ctrl: RTL and testbench

Time-multiplexing controller for the 4-digit seven-segment display path in DisplayNumber. It drives the 2-bit select of the per-bit 4:1 digit muxes, generates the active-low anode enables, and inserts a blanking gap between digits to suppress ghosting. It double-buffers a 16-bit BCD/hex value through a valid/ready handshake so a new value appears only on a frame boundary, and it optionally blanks leading zeros.

---
 rtl/display_scan_ctrl.sv | 100 ++++++++++
 tb/tb_display_scan_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed seven-segment display.
// Double-buffers the displayed value so it only changes on frame boundaries.
module display_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 8,
  parameter int CNT_W        = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] num_in,
  input  logic        num_valid,
  output logic        num_ready,
  input  logic        lz_blank_en,
  output logic [1:0]  sel,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        frame_done
);

  typedef enum logic {SHOW, BLANK} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [1:0]        sel_n;
  logic              wrap;
  logic [15:0]       shadow, pending;
  logic              pending_full;
  logic              take;
  logic [3:0]        lead_zero;

  assign num_ready = ~pending_full;
  assign take      = num_valid & ~pending_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SHOW;
      cnt          <= '0;
      sel          <= 2'd0;
      frame_done   <= 1'b0;
      shadow       <= 16'h0000;
      pending      <= 16'h0000;
      pending_full <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sel        <= sel_n;
      frame_done <= wrap;
      // A full buffer blocks new transfers, so a load and a take never coincide
      if (wrap && pending_full) begin
        shadow       <= pending;
        pending_full <= 1'b0;
      end else if (take) begin
        pending      <= num_in;
        pending_full <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    sel_n   = sel;
    wrap    = 1'b0;
    case (state)
      SHOW: begin
        if (cnt == CNT_W'(SCAN_DIV - 1)) begin
          cnt_n   = '0;
          state_n = BLANK;
        end
      end
      BLANK: begin
        if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
          cnt_n   = '0;
          sel_n   = sel + 2'd1;
          state_n = SHOW;
          wrap    = (sel == 2'd3);
        end
      end
      default: begin
        state_n = SHOW;
        cnt_n   = '0;
      end
    endcase
  end

  // lead_zero[i]: nibbles i..3 are all zero; digit 0 is never blanked
  assign lead_zero[3] = (shadow[15:12] == 4'h0);
  assign lead_zero[2] = lead_zero[3] & (shadow[11:8] == 4'h0);
  assign lead_zero[1] = lead_zero[2] & (shadow[7:4] == 4'h0);
  assign lead_zero[0] = 1'b0;

  assign digit = shadow[sel*4 +: 4];

  always_comb begin
    an = 4'hF;
    if (state == SHOW && !(lz_blank_en && lead_zero[sel]))
      an[sel] = 1'b0;
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl using a frame-position model
// and a scoreboard of expected outputs checked one cycle at a time.
module tb_display_scan_ctrl;

  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int PERIOD       = SCAN_DIV + BLANK_CYCLES;
  localparam int FRAME        = 4 * PERIOD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] num_in = 16'h0000;
  logic        num_valid = 1'b0;
  logic        num_ready;
  logic        lz_blank_en = 1'b0;
  logic [1:0]  sel;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        frame_done;

  display_scan_ctrl #(
    .SCAN_DIV(SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .num_in(num_in),
    .num_valid(num_valid),
    .num_ready(num_ready),
    .lz_blank_en(lz_blank_en),
    .sel(sel),
    .digit(digit),
    .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] an;
    logic [3:0] digit;
    logic       ready;
    logic       fd;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];
  int    checks = 0;
  int    errors = 0;

  // Model: position within the frame plus the double buffer
  int          m_pos;
  logic [15:0] m_shadow, m_pending;
  logic        m_full, m_fd;

  task automatic modelReset();
    m_pos    = 0;
    m_shadow = 16'h0000;
    m_pending = 16'h0000;
    m_full   = 1'b0;
    m_fd     = 1'b0;
  endtask

  task automatic modelAdvance(input logic v, input logic [15:0] n);
    logic boundary;
    logic accept;
    boundary = (m_pos == FRAME - 1);
    accept   = v && !m_full;
    if (boundary && m_full) begin
      m_shadow = m_pending;
      m_full   = 1'b0;
    end
    if (accept) begin
      m_pending = n;
      m_full    = 1'b1;
    end
    m_fd  = boundary;
    m_pos = (m_pos + 1) % FRAME;
  endtask

  function automatic exp_t predict();
    exp_t        e;
    int          d;
    logic [15:0] upper;
    logic        blanked;
    d       = m_pos / PERIOD;
    upper   = m_shadow >> (4 * d);
    blanked = lz_blank_en && (d != 0) && (upper == 16'h0000);
    e.sel   = 2'(d);
    e.digit = upper[3:0];
    e.an    = 4'hF;
    if ((m_pos % PERIOD) < SCAN_DIV && !blanked) e.an[d] = 1'b0;
    e.ready = ~m_full;
    e.fd    = m_fd;
    return e;
  endfunction

  task automatic checkOutput();
    exp_t  e;
    string t;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed 0 entries expected >=1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      t = sb_tag.pop_front();
      checks++;
      assert (sel === e.sel) else begin
        errors++;
        $error("[TB] FAIL %s sel observed %0h expected %0h", t, sel, e.sel);
      end
      checks++;
      assert (an === e.an) else begin
        errors++;
        $error("[TB] FAIL %s an observed %b expected %b", t, an, e.an);
      end
      checks++;
      assert (digit === e.digit) else begin
        errors++;
        $error("[TB] FAIL %s digit observed %0h expected %0h", t, digit, e.digit);
      end
      checks++;
      assert (num_ready === e.ready) else begin
        errors++;
        $error("[TB] FAIL %s num_ready observed %b expected %b", t, num_ready, e.ready);
      end
      checks++;
      assert (frame_done === e.fd) else begin
        errors++;
        $error("[TB] FAIL %s frame_done observed %b expected %b", t, frame_done, e.fd);
      end
    end
  endtask

  // Drive inputs for one cycle, advance the model on the edge, then compare
  task automatic applyStimulus(input logic v, input logic [15:0] n, input logic r,
                               input string tag);
    num_valid = v;
    num_in    = n;
    rst       = r;
    if (r) modelReset();
    @(posedge clk);
    if (!r) modelAdvance(v, n);
    sb.push_back(predict());
    sb_tag.push_back(tag);
    #1;
    checkOutput();
  endtask

  task automatic idleCycles(input int count, input string tag);
    for (int i = 0; i < count; i++) applyStimulus(1'b0, 16'h0000, 1'b0, tag);
  endtask

  task automatic loadValue(input logic [15:0] v, input string tag);
    for (int g = 0; g < 2 * FRAME && m_full; g++) idleCycles(1, "wait_ready");
    applyStimulus(1'b1, v, 1'b0, tag);
  endtask

  initial begin
    modelReset();
    $display("[TB] start");

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, 1'b1, "reset");

    idleCycles(7, "first_digits");
    applyStimulus(1'b1, 16'h1234, 1'b0, "load_1234");
    idleCycles(2 * FRAME, "show_1234");

    loadValue(16'hAAAA, "load_aaaa");
    for (int i = 0; i < 2 * FRAME; i++) applyStimulus(1'b1, 16'hBBBB, 1'b0, "hold_bbbb");
    idleCycles(FRAME + 4, "show_bbbb");

    lz_blank_en = 1'b1;
    loadValue(16'h0005, "load_0005");
    idleCycles(2 * FRAME, "lz_0005");
    loadValue(16'h0000, "load_0000");
    idleCycles(2 * FRAME, "lz_0000");
    loadValue(16'h0500, "load_0500");
    idleCycles(2 * FRAME, "lz_0500");

    lz_blank_en = 1'b0;
    loadValue(16'h0000, "load_0000_nolz");
    idleCycles(2 * FRAME, "nolz_0000");

    loadValue(16'h9999, "load_9999");
    for (int g = 0; g < FRAME && (m_pos % PERIOD) != SCAN_DIV; g++)
      idleCycles(1, "to_blank");
    rst = 1'b1;
    modelReset();
    #1;
    sb.push_back(predict());
    sb_tag.push_back("async_rst");
    checkOutput();
    applyStimulus(1'b0, 16'h0000, 1'b1, "rst_hold");
    idleCycles(2 * FRAME, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
